control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Moore sequencer for the 8-bit accumulator CPU: fetch/decode/execute of the
// instruction register plus a byte-at-a-time memory programming mode.
module control_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] opcode,
    input  logic       status,
    input  logic       zero_flag,
    input  logic       prog_mode,
    input  logic       prog_valid,
    output logic       prog_ready,
    output logic       MAR_load,
    output logic       PC_load,
    output logic       IR_load,
    output logic       PC_reset,
    output logic       IR_reset,
    output logic       en_inc,
    output logic       INC_ALU_select,
    output logic       IR_PC_select,
    output logic       Bc,
    output logic       APc,
    output logic       A_programmer_select,
    output logic       latch_PC_load,
    output logic       show_load,
    output logic       show_reset,
    output logic       A_load,
    output logic       mem_we,
    output logic       halted,
    output logic [1:0] alu_op
);

    // state      | meaning
    // RST        | clear PC, IR and display
    // FETCH1     | MAR <- PC
    // FETCH2     | IR <- mem[MAR]
    // FETCH3     | PC <- PC + 1
    // DECODE     | latch opcode, pick next state
    // EXEC1      | MAR <- operand, or latch jump target
    // EXEC2      | data move / ALU op / PC <- target
    // HALT       | idle until reset or programming
    // PROG_ADDR  | MAR <- PC, wait for programmer byte
    // PROG_WRITE | mem[MAR] <- programmer byte, PC <- PC + 1
    typedef enum logic [3:0] {
        S_RST, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_EXEC1, S_EXEC2, S_HALT, S_PROG_ADDR, S_PROG_WRITE
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_OUT = 3'b111;

    state_t     state, state_nxt;
    logic [2:0] op_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RST;
            op_r  <= OP_NOP;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) op_r <= opcode;
        end
    end

    always_comb begin
        state_nxt           = state;
        prog_ready          = 1'b0;
        MAR_load            = 1'b0;
        PC_load             = 1'b0;
        IR_load             = 1'b0;
        PC_reset            = 1'b0;
        IR_reset            = 1'b0;
        en_inc              = 1'b0;
        INC_ALU_select      = 1'b0;
        IR_PC_select        = 1'b0;
        Bc                  = 1'b0;
        APc                 = 1'b0;
        A_programmer_select = 1'b0;
        latch_PC_load       = 1'b0;
        show_load           = 1'b0;
        show_reset          = 1'b0;
        A_load              = 1'b0;
        mem_we              = 1'b0;
        halted              = 1'b0;
        alu_op              = 2'b00;

        case (state)
            S_RST: begin
                PC_reset   = 1'b1;
                IR_reset   = 1'b1;
                show_reset = 1'b1;
                state_nxt  = prog_mode ? S_PROG_ADDR : S_FETCH1;
            end
            S_FETCH1: begin
                MAR_load  = 1'b1;
                state_nxt = prog_mode ? S_PROG_ADDR : S_FETCH2;
            end
            S_FETCH2: begin
                Bc        = 1'b1;
                IR_load   = 1'b1;
                state_nxt = S_FETCH3;
            end
            S_FETCH3: begin
                en_inc         = 1'b1;
                INC_ALU_select = 1'b1;
                PC_load        = 1'b1;
                state_nxt      = S_DECODE;
            end
            S_DECODE: begin
                // HALT shares opcode 000 with NOP, so status must win
                if (!status)                             state_nxt = S_HALT;
                else if (opcode == OP_NOP)               state_nxt = S_FETCH1;
                else if (opcode == OP_JZ && !zero_flag)  state_nxt = S_FETCH1;
                else                                     state_nxt = S_EXEC1;
            end
            S_EXEC1: begin
                state_nxt = S_EXEC2;
                case (op_r)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_OUT: begin
                        MAR_load     = 1'b1;
                        IR_PC_select = 1'b1;
                    end
                    OP_JMP, OP_JZ: begin
                        latch_PC_load = 1'b1;
                        alu_op        = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_EXEC2: begin
                state_nxt = S_FETCH1;
                case (op_r)
                    OP_LDA: begin Bc = 1'b1; A_load = 1'b1; alu_op = 2'b10; end
                    OP_STA: begin A_programmer_select = 1'b1; APc = 1'b1; mem_we = 1'b1; end
                    OP_ADD: begin Bc = 1'b1; A_load = 1'b1; alu_op = 2'b00; end
                    OP_SUB: begin Bc = 1'b1; A_load = 1'b1; alu_op = 2'b01; end
                    OP_JMP, OP_JZ: PC_load = 1'b1;
                    OP_OUT: begin Bc = 1'b1; show_load = 1'b1; end
                    default: ;
                endcase
            end
            S_HALT: begin
                halted    = 1'b1;
                state_nxt = prog_mode ? S_PROG_ADDR : S_HALT;
            end
            S_PROG_ADDR: begin
                MAR_load = 1'b1;
                if (!prog_mode)      state_nxt = S_RST;
                else if (prog_valid) state_nxt = S_PROG_WRITE;
            end
            S_PROG_WRITE: begin
                APc            = 1'b1;
                mem_we         = 1'b1;
                prog_ready     = 1'b1;
                en_inc         = 1'b1;
                INC_ALU_select = 1'b1;
                PC_load        = 1'b1;
                state_nxt      = S_PROG_ADDR;
            end
            default: state_nxt = S_RST;
        endcase
    end

endmodule
